mac_dot_sequencer: RTL and testbench

//  Initiator/controller for one MAC accumulator: accepts a dot-product command (length N),

---
 rtl/mac_dot_sequencer.sv | 164 ++++++++++++++++
 tb/tb_mac_dot_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer
// Controller sitting in front of one MAC accumulator. It accepts a dot-product
// command of length N and clears the MAC. It then streams N operand pairs into
// the MAC and flushes the MAC's two-stage multiply/accumulate pipe. Finally it
// captures the total and the sticky overflow flag into a valid/ready result port.
//
// MAC contract assumed here: while run=1 the MAC registers in1*in2 and adds
// the previously registered product to its total. While run=0 both stages
// hold. So the last product only reaches the total after one extra run cycle
// with zero operands (FLUSH), and the total is readable the cycle after that
// (CAPTURE).
module mac_dot_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int ACCUM_WIDTH = 2 * DATA_WIDTH,
  parameter int LEN_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // command port
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [LEN_W-1:0]       cmd_len,
  input  logic                   abort,
  // operand stream
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [DATA_WIDTH-1:0]  op_a,
  input  logic [DATA_WIDTH-1:0]  op_b,
  // attached MAC
  output logic                   mac_clr,
  output logic                   mac_run,
  output logic [DATA_WIDTH-1:0]  mac_in1,
  output logic [DATA_WIDTH-1:0]  mac_in2,
  input  logic [ACCUM_WIDTH-1:0] mac_total,
  input  logic                   mac_err,
  // result port
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ACCUM_WIDTH-1:0] res_data,
  output logic                   res_err,
  // status
  output logic                   busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_FEED    = 3'd2,
    S_FLUSH   = 3'd3,
    S_CAPTURE = 3'd4,
    S_RESULT  = 3'd5
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ZERO = '0;
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [LEN_W-1:0]       remaining_q, remaining_d;
  logic [ACCUM_WIDTH-1:0] res_data_q, res_data_d;
  logic                   res_err_q, res_err_d;

  // State, remaining-pair count and captured result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      remaining_q <= LEN_ZERO;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
    end
  end

  // Next-state and output decode; abort is applied last so it overrides everything.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    cmd_ready   = 1'b0;
    op_ready    = 1'b0;
    mac_clr     = 1'b0;
    mac_run     = 1'b0;
    mac_in1     = '0;
    mac_in2     = '0;
    res_valid   = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          remaining_d = cmd_len;
          state_d     = S_CLEAR;
        end
      end

      S_CLEAR: begin
        // Zero the MAC total, product stage and sticky error before the job.
        mac_clr = 1'b1;
        state_d = (remaining_q != LEN_ZERO) ? S_FEED : S_FLUSH;
      end

      S_FEED: begin
        // run follows op_valid so a stall freezes the MAC pipe rather than
        // pushing a zero product through it.
        op_ready = 1'b1;
        if (op_valid) begin
          mac_run     = 1'b1;
          mac_in1     = op_a;
          mac_in2     = op_b;
          remaining_d = remaining_q - LEN_ONE;
          if (remaining_q == LEN_ONE) begin
            state_d = S_FLUSH;
          end
        end
      end

      S_FLUSH: begin
        // One run with zero operands moves the last registered product into the total.
        mac_run = 1'b1;
        state_d = S_CAPTURE;
      end

      S_CAPTURE: begin
        res_data_d = mac_total;
        res_err_d  = mac_err;
        state_d    = S_RESULT;
      end

      S_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort drops the job wherever it is: reset the MAC, discard any result.
    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      remaining_d = LEN_ZERO;
      res_data_d  = '0;
      res_err_d   = 1'b0;
      mac_clr     = 1'b1;
      mac_run     = 1'b0;
      mac_in1     = '0;
      mac_in2     = '0;
      op_ready    = 1'b0;
      res_valid   = 1'b0;
    end
  end

  assign res_data = res_data_q;
  assign res_err  = res_err_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// tb_mac_dot_sequencer
// Drives dot-product jobs through mac_dot_sequencer attached to a behavioural
// two-stage MAC. Expected results come from a reference dot-product function
// and go onto a scoreboard queue when a command is issued. They are popped
// and compared when the result handshake happens.
module tb_mac_dot_sequencer;

  localparam int DW = 16;
  localparam int AW = 32;
  localparam int LW = 8;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len;
  logic          abort;
  logic          op_valid;
  logic          op_ready;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          mac_clr;
  logic          mac_run;
  logic [DW-1:0] mac_in1;
  logic [DW-1:0] mac_in2;
  logic [AW-1:0] mac_total;
  logic          mac_err;
  logic          res_valid;
  logic          res_ready;
  logic [AW-1:0] res_data;
  logic          res_err;
  logic          busy;

  mac_dot_sequencer #(.DATA_WIDTH(DW), .ACCUM_WIDTH(AW), .LEN_W(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .abort     (abort),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .mac_clr   (mac_clr),
    .mac_run   (mac_run),
    .mac_in1   (mac_in1),
    .mac_in2   (mac_in2),
    .mac_total (mac_total),
    .mac_err   (mac_err),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MAC: product register, then wrap-around accumulate with sticky signed overflow.
  logic signed [AW-1:0] m1, m2, prod_q, total_q, sum_w;
  logic                 err_q, ovf_w;
  int                   run_cnt;
  assign m1        = {{(AW-DW){mac_in1[DW-1]}}, mac_in1};
  assign m2        = {{(AW-DW){mac_in2[DW-1]}}, mac_in2};
  assign sum_w     = total_q + prod_q;
  assign ovf_w     = (total_q[AW-1] == prod_q[AW-1]) && (sum_w[AW-1] != total_q[AW-1]);
  assign mac_total = total_q;
  assign mac_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= '0;
      total_q <= '0;
      err_q   <= 1'b0;
      run_cnt <= 0;
    end else if (mac_clr) begin
      prod_q  <= '0;
      total_q <= '0;
      err_q   <= 1'b0;
      run_cnt <= 0;
    end else if (mac_run) begin
      prod_q  <= m1 * m2;
      total_q <= sum_w;
      err_q   <= err_q | ovf_w;
      run_cnt <= run_cnt + 1;
    end
  end

  typedef struct {
    logic [AW-1:0] data;
    logic          err;
  } exp_t;

  exp_t                 sb[$];
  logic signed [DW-1:0] va[16];
  logic signed [DW-1:0] vb[16];
  int                   tests_run = 0;
  int                   tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_pair(input int i, input int a, input int b);
    va[i] = 16'(a);
    vb[i] = 16'(b);
  endtask

  // Reference dot product over the first n pairs of va/vb.
  function automatic exp_t ref_dot(input int n);
    exp_t                 r;
    logic signed [AW-1:0] t, p, s, pa, pb;
    t     = '0;
    r.err = 1'b0;
    for (int i = 0; i < n; i++) begin
      pa = {{(AW-DW){va[i][DW-1]}}, va[i]};
      pb = {{(AW-DW){vb[i][DW-1]}}, vb[i]};
      p  = pa * pb;
      s  = t + p;
      if ((t[AW-1] == p[AW-1]) && (s[AW-1] != t[AW-1])) r.err = 1'b1;
      t = s;
    end
    r.data = t;
    return r;
  endfunction

  // Full job: command, operand feed with optional gaps, result held off for 'hold' cycles.
  task automatic run_job(input int n, input int gap, input int hold, input bit abort_idle);
    exp_t          e;
    int            k;
    int            idx;
    int            gcnt;
    int            exp_lat;
    bit            done;
    logic [AW-1:0] held;
    exp_lat = n + 3 + gap * ((n > 1) ? (n - 1) : 0);
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1);
    check("op_ready_idle", op_ready, 0);
    cmd_valid = 1'b1;
    cmd_len   = 8'(n);
    abort     = abort_idle;
    sb.push_back(ref_dot(n));
    @(negedge clk);
    cmd_valid = 1'b0;
    abort     = 1'b0;
    check("busy_after_accept", busy, 1);
    check("clr_in_clear", mac_clr, 1);
    k    = 0;
    idx  = 0;
    gcnt = 0;
    done = 1'b0;
    while (!done && k < 200) begin
      if (res_valid) begin
        done = 1'b1;
      end else begin
        if (idx < n && gcnt == 0) begin
          op_valid = 1'b1;
          op_a     = va[idx];
          op_b     = vb[idx];
        end else begin
          op_valid = 1'b0;
          op_a     = '0;
          op_b     = '0;
        end
        if (op_ready) begin
          if (op_valid) begin
            idx++;
            gcnt = gap;
          end else if (gcnt > 0) begin
            gcnt--;
            #1 check("run_in_gap", mac_run, 0);
          end
        end
        @(negedge clk);
        k++;
      end
    end
    op_valid = 1'b0;
    op_a     = '0;
    op_b     = '0;
    if (!done) begin
      check("res_valid_timeout", 1, 0);
      return;
    end
    check("latency", k, exp_lat);
    check("mac_runs", run_cnt, n + 1);
    held = res_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", res_valid, 1);
      check("hold_data", res_data, held);
      check("hold_cmd_ready", cmd_ready, 0);
    end
    res_ready = 1'b1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check("res_data", res_data, e.data);
      check("res_err", res_err, e.err);
      $display("[TB] job n=%0d gap=%0d hold=%0d data=0x%08h err=%0b latency=%0d", n, gap, hold, res_data, res_err, k);
    end
    @(negedge clk);
    res_ready = 1'b0;
    check("valid_drop", res_valid, 0);
    check("cmd_ready_back", cmd_ready, 1);
  endtask

  // Abort a 4-pair job after its first transfer.
  task automatic abort_job();
    int idx;
    int k;
    set_pair(0, 1, 1); set_pair(1, 2, 2); set_pair(2, 3, 3); set_pair(3, 4, 4);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_len   = 8'd4;
    @(negedge clk);
    cmd_valid = 1'b0;
    idx = 0;
    k   = 0;
    while (idx < 1 && k < 50) begin
      op_valid = 1'b1;
      op_a     = va[idx];
      op_b     = vb[idx];
      if (op_ready) idx++;
      @(negedge clk);
      k++;
    end
    check("abort_feed_reached", idx, 1);
    op_valid = 1'b1;
    op_a     = va[1];
    op_b     = vb[1];
    abort    = 1'b1;
    #1;
    check("abort_clr", mac_clr, 1);
    check("abort_run", mac_run, 0);
    check("abort_op_ready", op_ready, 0);
    check("abort_res_valid", res_valid, 0);
    @(negedge clk);
    abort    = 1'b0;
    op_valid = 1'b0;
    op_a     = '0;
    op_b     = '0;
    check("abort_idle", busy, 0);
    check("abort_res_data", res_data, 0);
    check("abort_res_err", res_err, 0);
    check("abort_cmd_ready", cmd_ready, 1);
    $display("[TB] job aborted after %0d pair(s)", idx);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    abort     = 1'b0;
    op_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_err", res_err, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_mac_clr", mac_clr, 0);
    check("rst_mac_run", mac_run, 0);
    check("rst_mac_in1", mac_in1, 0);
    check("rst_op_ready", op_ready, 0);
    rst_n = 1'b1;

    // Basic three-pair job, then the same with two-cycle operand gaps.
    set_pair(0, 2, 3); set_pair(1, 4, 5); set_pair(2, -1, 7);
    run_job(3, 0, 0, 1'b0);
    run_job(3, 2, 0, 1'b0);

    // Most-negative operands: 2^30 + 2^30 wraps to 0x8000_0000 with overflow.
    set_pair(0, -32768, -32768); set_pair(1, -32768, -32768);
    run_job(2, 0, 0, 1'b0);

    // Empty job.
    run_job(0, 0, 0, 1'b0);

    // Back-pressured result, then an immediate follow-up job.
    set_pair(0, 2, 3); set_pair(1, 4, 5); set_pair(2, -1, 7);
    run_job(3, 0, 5, 1'b0);
    set_pair(0, 1000, -1000); set_pair(1, 300, 300);
    run_job(2, 0, 0, 1'b0);

    // Abort mid-feed, then a single-pair job.
    abort_job();
    set_pair(0, 6, 7);
    run_job(1, 0, 0, 1'b0);

    // Asynchronous reset in the middle of a job.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_len   = 8'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("amid_rst_busy", busy, 0);
    check("amid_rst_res_data", res_data, 0);
    check("amid_rst_cmd_ready", cmd_ready, 1);
    check("amid_rst_mac_total", mac_total, 0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] job reset mid-feed");

    // Abort asserted in IDLE alongside a command: command still runs.
    set_pair(0, 100, -3); set_pair(1, 7, 7);
    run_job(2, 0, 0, 1'b1);

    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
